// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, two-read register file with scoreboard busy bits and reservation port
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG),
    localparam int CW    = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ok,
    output logic            busy1,
    output logic            busy2,
    output logic [CW-1:0]   busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_nxt;

    logic wr0, wr1;
    logic hit1_0, hit1_1, hit2_0, hit2_1;
    logic rsv_wr_hit;

    // A write to address 0 is not a write at all: it neither stores nor clears.
    assign wr0 = we0 && (wa0 != '0);
    assign wr1 = we1 && (wa1 != '0);

    assign hit1_0 = wr0 && (wa0 == ra1);
    assign hit1_1 = wr1 && (wa1 == ra1);
    assign hit2_0 = wr0 && (wa0 == ra2);
    assign hit2_1 = wr1 && (wa1 == ra2);

    assign rsv_wr_hit = (wr0 && (wa0 == rsv_addr)) || (wr1 && (wa1 == rsv_addr));

    always_comb begin
        rd1 = '0;
        if (rst && (ra1 != '0)) begin
            if ((BYPASS != 0) && hit1_1)      rd1 = wd1;
            else if ((BYPASS != 0) && hit1_0) rd1 = wd0;
            else                              rd1 = regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rst && (ra2 != '0)) begin
            if ((BYPASS != 0) && hit2_1)      rd2 = wd1;
            else if ((BYPASS != 0) && hit2_0) rd2 = wd0;
            else                              rd2 = regs[ra2];
        end
    end

    assign busy1 = rst && (ra1 != '0) && busy[ra1] && !((BYPASS != 0) && (hit1_0 || hit1_1));
    assign busy2 = rst && (ra2 != '0) && busy[ra2] && !((BYPASS != 0) && (hit2_0 || hit2_1));

    assign rsv_ok = rst && rsv_en && ((rsv_addr == '0) || !busy[rsv_addr] || rsv_wr_hit);

    // Set after clear so a reservation wins over a same-cycle write-back.
    always_comb begin
        busy_nxt = busy;
        if (wr0) busy_nxt[wa0] = 1'b0;
        if (wr1) busy_nxt[wa1] = 1'b0;
        if (rsv_ok && (rsv_addr != '0)) busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr1 && (wa1 == AW'(i)))      regs[i] <= wd1;
                else if (wr0 && (wa0 == AW'(i))) regs[i] <= wd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table, directed and random checks of regfile_sb against a behavioural model
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok, nb_rsv_ok;
    logic        busy1, busy2, nb_busy1, nb_busy2;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
        .busy1(nb_busy1), .busy2(nb_busy2), .busy_cnt(nb_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        ra1 = 0; ra2 = 0; rsv_en = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Reference model: architectural register values and busy set
    logic [31:0] mreg [32];
    logic [31:0] mbusy;

    function automatic logic wr_targets(input logic [4:0] a);
        return (a != 0) && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        return (a != 0) && mbusy[a] && !(byp && wr_targets(a));
    endfunction

    function automatic logic exp_ok();
        return rsv_en && (rsv_addr == 0 || !mbusy[rsv_addr] || wr_targets(rsv_addr));
    endfunction

    task automatic model_edge();
        logic ok;
        ok = exp_ok();
        if (we0 && wa0 != 0) begin mreg[wa0] = wd0; mbusy[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin mreg[wa1] = wd1; mbusy[wa1] = 1'b0; end
        if (ok && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
    endtask

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic [4:0]  ra1; logic [4:0] ra2;
        logic        rsv_en; logic [4:0] rsv_addr;
        logic [31:0] e_rd1; logic [31:0] e_rd2; logic [31:0] e_nb_rd1;
        logic        e_ok; logic e_b1; logic e_b2; logic [5:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,  5, 0, 0, 0,  32'hDEADBEEF, 0, 0,             0, 0, 0, 0};
        tbl[1] = '{1, 0, 32'h1234,     0, 0, 0,  5, 0, 0, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF,  0, 0, 0, 0};
        tbl[2] = '{1, 7, 32'h11,       1, 7, 32'h22, 7, 5, 0, 0, 32'h22, 32'hDEADBEEF, 0,     0, 0, 0, 0};
        tbl[3] = '{0, 0, 0,            0, 0, 0,  7, 3, 1, 3,  32'h22, 0, 32'h22,              1, 0, 0, 1};
        tbl[4] = '{0, 0, 0,            0, 0, 0,  3, 0, 1, 3,  0, 0, 0,                        0, 1, 0, 1};
        tbl[5] = '{1, 3, 32'hAA,       0, 0, 0,  3, 0, 0, 0,  32'hAA, 0, 0,                   0, 0, 0, 0};
        tbl[6] = '{0, 0, 0,            0, 0, 0,  0, 0, 1, 4,  0, 0, 0,                        1, 0, 0, 1};
        tbl[7] = '{1, 4, 32'h44,       0, 0, 0,  4, 3, 1, 4,  32'h44, 32'hAA, 0,              1, 0, 0, 1};
        tbl[8] = '{0, 0, 0,            0, 0, 0,  4, 0, 1, 0,  32'h44, 0, 32'h44,              1, 1, 0, 1};
        tbl[9] = '{0, 0, 0,            1, 4, 32'h55, 4, 4, 0, 0, 32'h55, 32'h55, 32'h44,      0, 0, 0, 0};

        rst = 1'b0;
        idle_inputs();
        ra1 = 5; ra2 = 9; rsv_en = 1; rsv_addr = 6;
        #2;
        check("reset_rd1", rd1, 0);
        check("reset_rd2", rd2, 0);
        check("reset_cnt", busy_cnt, 0);
        check("reset_rsv_ok", rsv_ok, 0);
        check("reset_busy1", busy1, 0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            rsv_en = tbl[i].rsv_en; rsv_addr = tbl[i].rsv_addr;
            @(negedge clk);
            check($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e_rd1);
            check($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e_rd2);
            check($sformatf("tbl%0d_nb_rd1", i), nb_rd1, tbl[i].e_nb_rd1);
            check($sformatf("tbl%0d_rsv_ok", i), rsv_ok, tbl[i].e_ok);
            check($sformatf("tbl%0d_busy1", i), busy1, tbl[i].e_b1);
            check($sformatf("tbl%0d_busy2", i), busy2, tbl[i].e_b2);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_cnt", i), busy_cnt, tbl[i].e_cnt);
        end

        // Fill the scoreboard, then clear two and re-reserve one in one cycle
        do_reset();
        for (int a = 1; a < 32; a++) begin
            idle_inputs();
            rsv_en = 1; rsv_addr = 5'(a);
            @(negedge clk);
            check($sformatf("fill_ok_%0d", a), rsv_ok, 1);
            @(posedge clk); #1;
        end
        check("fill_cnt", busy_cnt, 31);
        idle_inputs();
        we0 = 1; wa0 = 1; wd0 = 32'h101; we1 = 1; wa1 = 2; wd1 = 32'h202;
        rsv_en = 1; rsv_addr = 1;
        @(negedge clk);
        check("clr2_rsv1_ok", rsv_ok, 1);
        @(posedge clk); #1;
        check("clr2_rsv1_cnt", busy_cnt, 30);

        // Asynchronous reset in the middle of a busy burst
        do_reset();
        for (int a = 1; a <= 10; a++) begin
            idle_inputs();
            rsv_en = 1; rsv_addr = 5'(a);
            we0 = 1; wa0 = 5'(a); wd0 = 32'hC000 + 32'(a);
            @(posedge clk); #1;
        end
        check("burst_cnt", busy_cnt, 10);
        idle_inputs();
        we0 = 1; wa0 = 11; wd0 = 32'hBAD; rsv_en = 1; rsv_addr = 12;
        ra1 = 5; ra2 = 11;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rd1", rd1, 0);
        check("mid_rst_rd2", rd2, 0);
        check("mid_rst_cnt", busy_cnt, 0);
        check("mid_rst_ok", rsv_ok, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        ra1 = 11; ra2 = 5; rsv_en = 1; rsv_addr = 5;
        @(negedge clk);
        check("post_rst_rd1", rd1, 0);
        check("post_rst_rd2", rd2, 0);
        check("post_rst_ok", rsv_ok, 1);
        @(posedge clk); #1;
        check("post_rst_cnt", busy_cnt, 1);

        // Randomized traffic against the model, both bypass variants
        do_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        mbusy = 0;
        for (int n = 0; n < 600; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa1 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            ra1 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra2 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rsv_en = ($urandom_range(0, 2) != 0);
            rsv_addr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            @(negedge clk);
            check("rnd_rd1", rd1, exp_rd(ra1, 1));
            check("rnd_rd2", rd2, exp_rd(ra2, 1));
            check("rnd_nb_rd1", nb_rd1, exp_rd(ra1, 0));
            check("rnd_nb_rd2", nb_rd2, exp_rd(ra2, 0));
            check("rnd_busy1", busy1, exp_busy(ra1, 1));
            check("rnd_busy2", busy2, exp_busy(ra2, 1));
            check("rnd_nb_busy1", nb_busy1, exp_busy(ra1, 0));
            check("rnd_nb_busy2", nb_busy2, exp_busy(ra2, 0));
            check("rnd_rsv_ok", rsv_ok, exp_ok());
            check("rnd_nb_rsv_ok", nb_rsv_ok, exp_ok());
            model_edge();
            @(posedge clk); #1;
            check("rnd_cnt", busy_cnt, $countones(mbusy));
            check("rnd_nb_cnt", nb_busy_cnt, $countones(mbusy));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port, in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 we0, we1  input  1 each  write enables for write ports 0 and 1.
REQ-007 wa0, wa1  input  AW each  write addresses.
REQ-008 wd0, wd1  input  XLEN each  write data.
REQ-009 ra1, ra2  input  AW each  read addresses.
REQ-010 rd1, rd2  output  XLEN each  read data.
REQ-011 rsv_en  input  1  request to reserve a destination register in the scoreboard.
REQ-012 rsv_addr  input  AW  register to reserve.
REQ-013 rsv_ok  output  1  reservation accepted this cycle.
REQ-014 busy1, busy2  output  1 each  register at ra1/ra2 has a pending write.
REQ-015 busy_cnt  output  clog2(NREG+1)  number of registers currently reserved.

Function
REQ-016 Register 0 SHALL read as zero; writes and reservations to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational from the register array, subject to REQ-019 and REQ-027.
REQ-018 Write on rising edge when weN=1 and waN!=0; if we0 and we1 both target the same address, port 1 data SHALL be stored.
REQ-019 BYPASS=1: rdK SHALL equal the winning write data when an enabled write targets raK!=0 in the same cycle. BYPASS=0: rdK SHALL show the old value until the edge.
REQ-020 Each register SHALL have one busy bit; an enabled write to waN SHALL clear busy[waN] at the edge.
REQ-021 rsv_ok = rsv_en & (rsv_addr==0 | ~busy[rsv_addr] | an enabled write targets rsv_addr this cycle), combinational.
REQ-022 When rsv_ok=1 and rsv_addr!=0, busy[rsv_addr] SHALL be set at the edge; this SHALL win over a same-cycle clear to that address.
REQ-023 When rsv_en=1 and rsv_ok=0, scoreboard state SHALL be unchanged; the requester retries.
REQ-024 busyK = busy[raK] & raK!=0, masked to 0 when BYPASS=1 and an enabled write targets raK this cycle.
REQ-025 busy_cnt SHALL be registered and SHALL equal the population count of the busy bits after each edge, for any mix of set and clear (range 0..NREG-1).
REQ-026 A write to a non-busy register SHALL be legal: the data is stored and the busy bits are unchanged.

Reset
REQ-027 While rst=0: every register and every busy bit SHALL be cleared asynchronously; busy_cnt=0; rd1=rd2=0; busy1=busy2=0; rsv_ok=0.
REQ-028 rst assertion mid-operation SHALL discard same-cycle writes and reservations; normal operation resumes on the first rising edge with rst=1.

Verification
VER-001 Reset, then we0=1, wa0=5, wd0=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF. Write x0=0x1234 -> ra2=0 returns 0.
VER-002 we0/we1 both to wa=7 with 0x11/0x22 -> rd1(ra1=7)=0x22 same cycle (BYPASS=1) and after the edge; BYPASS=0 -> old value until the edge.
VER-003 rsv_en, rsv_addr=3 -> rsv_ok=1, busy_cnt=1; reserve 3 again -> rsv_ok=0, cnt stays 1; ra1=3 -> busy1=1; write 3 -> busy1=0 in the same cycle (BYPASS=1), cnt=0 after the edge.
VER-004 Same cycle: write wa0=4 (busy) and rsv_addr=4 -> rsv_ok=1, busy[4] stays set, busy_cnt unchanged.
VER-005 Reserve 31 registers back-to-back -> busy_cnt=31; write-clear 2 and reserve 1 in one cycle -> busy_cnt=30.
VER-006 Assert rst mid-burst with busy_cnt=10 -> rd1/rd2/busy_cnt=0 immediately; after release, a read of any register returns 0 and reserving it gives rsv_ok=1.
